// File: rtl/dispense_ctrl.sv
// dispense_ctrl: downstream dispenser for the vending-machine FSM.
// Buffers transaction results in a small FIFO and dispenses the item first,
// then the change. Each actuator pulse waits for a done acknowledge. The
// block tracks the 5-tk coin inventory and latches a fault on timeout.
// Optional statistics counters are built only when DISPENSE_STATS_EN is
// defined. Otherwise items_sold/tk_returned are tied to zero.
module dispense_ctrl #(
   parameter int FIFO_DEPTH   = 4,
   parameter int PULSE_W      = 4,
   parameter int DONE_TIMEOUT = 16,
   parameter int COIN_INIT    = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valid,
   input  logic                        purchase,
   input  logic [1:0]                  cash_return,
   output logic                        req_ready,
   output logic                        item_pulse,
   input  logic                        item_done,
   output logic                        coin_pulse,
   input  logic                        coin_done,
   input  logic                        refill,
   output logic [7:0]                  coins_left,
   output logic                        short_change,
   output logic                        busy,
   output logic                        fault,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [15:0]                 items_sold,
   output logic [15:0]                 tk_returned
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (PULSE_W > DONE_TIMEOUT) ? PULSE_W : DONE_TIMEOUT;
   localparam int TW   = $clog2(TMAX) + 1;

   localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_W - 1);
   localparam logic [TW-1:0] WAIT_LAST   = TW'(DONE_TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_ZERO    = {TW{1'b0}};
   localparam logic [TW-1:0] TMR_ONE     = TW'(1);
   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ZERO    = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [7:0]    COIN_RELOAD = 8'(COIN_INIT);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_ITEM_PULSE = 3'd2,
      S_ITEM_WAIT  = 3'd3,
      S_COIN_PULSE = 3'd4,
      S_COIN_WAIT  = 3'd5,
      S_FAULT      = 3'd6
   } state_t;

   // Number of 5-tk coins owed for a cash_return code; 11 is treated as none.
   function automatic logic [1:0] coins_needed(input logic [1:0] code);
      case (code)
         2'b01:   coins_needed = 2'd1;
         2'b10:   coins_needed = 2'd2;
         default: coins_needed = 2'd0;
      endcase
   endfunction

   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    need_in_s, head_need_s, grant_s;
   logic          push_s, pop_s, head_buy_s;
   logic [2:0]    head_s;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0]    grant_q, grant_d;
   logic [7:0]    coins_q, coins_d;
   logic          item_pulse_q, coin_pulse_q, short_q, busy_q, fault_q;

   assign req_ready   = (count_q != FULL_CNT);
   assign need_in_s   = coins_needed(cash_return);
   // A request with nothing to dispense is accepted but never stored.
   assign push_s      = req_valid & req_ready & (purchase | (need_in_s != 2'd0));
   assign pop_s       = (state_q == S_LOAD);
   assign head_s      = mem_q[rd_ptr_q];
   assign head_need_s = head_s[1:0];
   assign head_buy_s  = head_s[2];
   // Clamp the change to the coins on hand so the inventory never wraps.
   assign grant_s     = ({6'd0, head_need_s} > coins_q) ? coins_q[1:0] : head_need_s;

   // FIFO occupancy next value; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write port (contents need no reset, pointers guard them).
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {purchase, need_in_s};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q <= count_d;
      end
   end

   // Dispense sequencer next state, timers, coin grant and inventory.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      grant_d = grant_q;
      coins_d = coins_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != CNT_ZERO) begin
               state_d = S_LOAD;
            end else if (refill) begin
               coins_d = COIN_RELOAD;
            end else begin
               coins_d = coins_q;
            end
         end
         S_LOAD: begin
            grant_d = grant_s;
            tmr_d   = TMR_ZERO;
            if (head_buy_s) begin
               state_d = S_ITEM_PULSE;
            end else if (grant_s != 2'd0) begin
               state_d = S_COIN_PULSE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ITEM_PULSE, S_COIN_PULSE: begin
            if (tmr_q == PULSE_LAST) begin
               tmr_d   = TMR_ZERO;
               state_d = (state_q == S_ITEM_PULSE) ? S_ITEM_WAIT : S_COIN_WAIT;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         S_ITEM_WAIT: begin
            if (item_done) begin
               tmr_d   = TMR_ZERO;
               state_d = (grant_q != 2'd0) ? S_COIN_PULSE : S_IDLE;
            end else if (tmr_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         S_COIN_WAIT: begin
            if (coin_done) begin
               tmr_d   = TMR_ZERO;
               coins_d = coins_q - 8'd1;
               grant_d = grant_q - 2'd1;
               state_d = (grant_q > 2'd1) ? S_COIN_PULSE : S_IDLE;
            end else if (tmr_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer registers plus registered outputs decoded from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tmr_q        <= TMR_ZERO;
         grant_q      <= 2'd0;
         coins_q      <= COIN_RELOAD;
         item_pulse_q <= 1'b0;
         coin_pulse_q <= 1'b0;
         short_q      <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         grant_q      <= grant_d;
         coins_q      <= coins_d;
         item_pulse_q <= (state_d == S_ITEM_PULSE);
         coin_pulse_q <= (state_d == S_COIN_PULSE);
         short_q      <= (state_d == S_LOAD) && ({6'd0, head_need_s} > coins_q);
         busy_q       <= (state_d != S_IDLE) || (count_d != CNT_ZERO);
         fault_q      <= (state_d == S_FAULT);
      end
   end

   assign item_pulse   = item_pulse_q;
   assign coin_pulse   = coin_pulse_q;
   assign short_change = short_q;
   assign busy         = busy_q;
   assign fault        = fault_q;
   assign coins_left   = coins_q;
   assign fifo_count   = count_q;

`ifdef DISPENSE_STATS_EN
   logic [15:0] items_q, tk_q;

   // Saturating counters of acknowledged items and returned cash.
   always_ff @(posedge clock) begin
      if (reset) begin
         items_q <= 16'h0000;
         tk_q    <= 16'h0000;
      end else begin
         if ((state_q == S_ITEM_WAIT) && item_done && (items_q != 16'hFFFF)) begin
            items_q <= items_q + 16'd1;
         end
         if ((state_q == S_COIN_WAIT) && coin_done) begin
            tk_q <= (tk_q > 16'hFFFA) ? 16'hFFFF : tk_q + 16'd5;
         end
      end
   end

   assign items_sold  = items_q;
   assign tk_returned = tk_q;
`else
   assign items_sold  = 16'h0000;
   assign tk_returned = 16'h0000;
`endif

endmodule
